poly_deci_tap_ctrl: RTL and testbench

Coefficient and clock-enable controller for the polyphase decimator. It holds a double-buffered tap bank: software writes into a shadow bank, and the controller copies it atomically into the active bank on a decimator output-phase boundary. It also generates the decimator input `cke` from a programmable divider and suppresses it for one cycle around each swap. It sits between the register/config interface and the decimator's `tap`/`cke`/`cke_out` pins.

---
 rtl/poly_deci_tap_ctrl_if.sv | 49 ++++
 rtl/poly_deci_tap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_poly_deci_tap_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/poly_deci_tap_ctrl_if.sv
// Bus between the register/config side and the polyphase decimator tap controller.
// Readback signals exist only when POLY_TAP_RDBK_EN is defined.
interface poly_deci_tap_ctrl_if #(
  parameter int TAP_LEN = 16,
  parameter int WIDTH   = 16,
  parameter int DIV_W   = 8
);
  localparam int AW = (TAP_LEN > 1) ? $clog2(TAP_LEN) : 1;

  logic                       run;
  logic [DIV_W-1:0]           cke_div;
  logic                       cke;
  logic                       phase_strobe;
  logic                       wr_valid;
  logic                       wr_ready;
  logic [AW-1:0]              wr_addr;
  logic signed [WIDTH-1:0]    wr_data;
  logic                       commit;
  logic                       swap_pulse;
  logic                       busy;
  logic                       addr_err;
  logic                       err_clr;
  logic [TAP_LEN*WIDTH-1:0]   tap;
`ifdef POLY_TAP_RDBK_EN
  logic [AW-1:0]              rd_addr;
  logic                       rd_sel;
  logic signed [WIDTH-1:0]    rd_data;

  modport master (
    output run, cke_div, phase_strobe, wr_valid, wr_addr, wr_data, commit, err_clr,
           rd_addr, rd_sel,
    input  cke, wr_ready, swap_pulse, busy, addr_err, tap, rd_data
  );
  modport slave (
    input  run, cke_div, phase_strobe, wr_valid, wr_addr, wr_data, commit, err_clr,
           rd_addr, rd_sel,
    output cke, wr_ready, swap_pulse, busy, addr_err, tap, rd_data
  );
`else
  modport master (
    output run, cke_div, phase_strobe, wr_valid, wr_addr, wr_data, commit, err_clr,
    input  cke, wr_ready, swap_pulse, busy, addr_err, tap
  );
  modport slave (
    input  run, cke_div, phase_strobe, wr_valid, wr_addr, wr_data, commit, err_clr,
    output cke, wr_ready, swap_pulse, busy, addr_err, tap
  );
`endif
endinterface

// File: rtl/poly_deci_tap_ctrl.sv
// Double-buffered tap bank with phase-aligned atomic swap and cke divider for the polyphase decimator.
// Optional coefficient readback port enabled by defining POLY_TAP_RDBK_EN.
module poly_deci_tap_ctrl #(
  parameter int TAP_LEN = 16,
  parameter int WIDTH   = 16,
  parameter int DIV_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  poly_deci_tap_ctrl_if.slave bus
);
  localparam int AW = (TAP_LEN > 1) ? $clog2(TAP_LEN) : 1;
  localparam logic [AW:0] LEN_C = (AW+1)'(TAP_LEN);

  typedef enum logic [1:0] {IDLE, PEND, SWAP} state_t;

  state_t                  state_q;
  logic                    go_q;
  logic                    wr_ready_q;
  logic                    busy_q;
  logic                    swap_pulse_q;
  logic                    addr_err_q;
  logic                    cke_q;
  logic [DIV_W-1:0]        cnt_q;
  logic [DIV_W-1:0]        div_q;
  logic signed [WIDTH-1:0] active_q [TAP_LEN];
  logic signed [WIDTH-1:0] shadow_q [TAP_LEN];

  logic                    wr_fire;
  logic                    wr_in_range;
  logic                    swap_enter;
  logic [DIV_W-1:0]        div_lim;

  assign wr_fire     = bus.wr_valid & wr_ready_q;
  assign wr_in_range = {1'b0, bus.wr_addr} < LEN_C;
  assign swap_enter  = (state_q == PEND) & go_q;
  // The period length is sampled at counter 0, so a new cke_div starts after the current wrap.
  assign div_lim     = (cnt_q == '0) ? bus.cke_div : div_q;

  // ---- commit state machine ----
  // The phase boundary is registered in go_q, so the copy lands two edges after the strobe edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      go_q         <= 1'b0;
      wr_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      swap_pulse_q <= 1'b0;
    end else begin
      swap_pulse_q <= 1'b0;
      go_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.commit) begin
            state_q    <= PEND;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        PEND: begin
          if (go_q) state_q <= SWAP;
          else      go_q    <= bus.phase_strobe | ~bus.run;
        end
        SWAP: begin
          state_q      <= IDLE;
          wr_ready_q   <= 1'b1;
          busy_q       <= 1'b0;
          swap_pulse_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // ---- tap banks ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAP_LEN; i++) begin
        active_q[i] <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      if (state_q == SWAP) begin
        for (int i = 0; i < TAP_LEN; i++) active_q[i] <= shadow_q[i];
      end
      if (wr_fire && wr_in_range) shadow_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---- sticky address error: a new error outranks the clear ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q <= 1'b0;
    end else if (wr_fire && !wr_in_range) begin
      addr_err_q <= 1'b1;
    end else if (bus.err_clr) begin
      addr_err_q <= 1'b0;
    end
  end

  // ---- cke divider ----
  // On the edge entering SWAP the counter freezes, so a cke due there slips one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      div_q <= '0;
      cke_q <= 1'b0;
    end else if (!bus.run) begin
      cnt_q <= '0;
      div_q <= bus.cke_div;
      cke_q <= 1'b0;
    end else if (swap_enter) begin
      cke_q <= 1'b0;
    end else begin
      if (cnt_q == '0) div_q <= bus.cke_div;
      if (cnt_q == div_lim) begin
        cnt_q <= '0;
        cke_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        cke_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < TAP_LEN; g++) begin : g_tap
    assign bus.tap[g*WIDTH +: WIDTH] = active_q[g];
  end

  assign bus.cke        = cke_q;
  assign bus.wr_ready   = wr_ready_q;
  assign bus.swap_pulse = swap_pulse_q;
  assign bus.busy       = busy_q;
  assign bus.addr_err   = addr_err_q;

`ifdef POLY_TAP_RDBK_EN
  // ---- coefficient readback ----
  logic                    rd_in_range;
  logic signed [WIDTH-1:0] rd_data_q;

  assign rd_in_range = {1'b0, bus.rd_addr} < LEN_C;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (!rd_in_range) begin
      rd_data_q <= '0;
    end else if (bus.rd_sel) begin
      rd_data_q <= shadow_q[bus.rd_addr];
    end else begin
      rd_data_q <= active_q[bus.rd_addr];
    end
  end

  assign bus.rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_poly_deci_tap_ctrl.sv
// Scoreboard bench for poly_deci_tap_ctrl: commits push the expected active bank, a monitor checks it on swap_pulse.
module tb_poly_deci_tap_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  poly_deci_tap_ctrl_if #(.TAP_LEN(16), .WIDTH(16), .DIV_W(8)) bus ();
  poly_deci_tap_ctrl_if #(.TAP_LEN(12), .WIDTH(16), .DIV_W(8)) b12 ();

  poly_deci_tap_ctrl #(.TAP_LEN(16), .WIDTH(16), .DIV_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  poly_deci_tap_ctrl #(.TAP_LEN(12), .WIDTH(16), .DIV_W(8)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (b12)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [255:0] exp_q [$];
  logic [255:0] cur_tap = '0;
  logic [15:0]  shm [16];
  logic [191:0] exp12;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack_shadow();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = shm[i];
    return v;
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'(a);
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
    shm[a] = d;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    exp_q.push_back(pack_shadow());
  endtask

  task automatic wait_swap(input string nm);
    int k = 0;
    while (bus.swap_pulse !== 1'b1 && k < 12) begin
      tick();
      k++;
    end
    check(nm, 256'(bus.swap_pulse), 256'd1);
    tick();
  endtask

  // Monitor: every swap_pulse must match the oldest outstanding commit; otherwise tap must hold.
  always @(negedge clk) begin
    if (!rst) begin
      cur_tap = '0;
      exp_q.delete();
    end else if (bus.swap_pulse) begin
      if (exp_q.size() == 0) begin
        check("swap_unexpected", 256'd1, 256'd0);
      end else begin
        cur_tap = exp_q.pop_front();
        check("tap_on_swap", bus.tap, cur_tap);
      end
    end else begin
      check("tap_hold", bus.tap, cur_tap);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) shm[i] = '0;
    bus.run = 0; bus.cke_div = 0; bus.phase_strobe = 0; bus.wr_valid = 0;
    bus.wr_addr = 0; bus.wr_data = 0; bus.commit = 0; bus.err_clr = 0;
    b12.run = 0; b12.cke_div = 0; b12.phase_strobe = 0; b12.wr_valid = 0;
    b12.wr_addr = 0; b12.wr_data = 0; b12.commit = 0; b12.err_clr = 0;

    // Reset state
    repeat (3) tick();
    check("rst_cke", 256'(bus.cke), 256'd0);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_swap", 256'(bus.swap_pulse), 256'd0);
    check("rst_err", 256'(bus.addr_err), 256'd0);
    check("rst_tap", bus.tap, 256'd0);
    rst = 1'b1;
    tick();
    check("rel_wr_ready", 256'(bus.wr_ready), 256'd1);

    // Test 1: cke_div=3 gives one cke in four, first after four edges
    bus.cke_div = 8'd3;
    bus.run     = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("cke_div3_%0d", k), 256'(bus.cke), 256'((k % 4) == 0));
    end
    bus.run = 1'b0;
    tick();
    check("cke_run0", 256'(bus.cke), 256'd0);

    // Test 2: full shadow load, commit, strobe five cycles later
    bus.run = 1'b1;
    for (int i = 0; i < 16; i++) wr(i, 16'h0100 + 16'(i));
    do_commit();
    check("t2_busy_commit", 256'(bus.busy), 256'd1);
    check("t2_wr_ready_pend", 256'(bus.wr_ready), 256'd0);
    repeat (4) tick();
    bus.phase_strobe = 1'b1;
    tick();
    bus.phase_strobe = 1'b0;
    check("t2_swap_a0", 256'(bus.swap_pulse), 256'd0);
    tick();
    check("t2_busy_swap", 256'(bus.busy), 256'd1);
    check("t2_swap_a1", 256'(bus.swap_pulse), 256'd0);
    tick();
    check("t2_swap_a2", 256'(bus.swap_pulse), 256'd1);
    check("t2_busy_done", 256'(bus.busy), 256'd0);
    check("t2_wr_ready_idle", 256'(bus.wr_ready), 256'd1);
    tick();
    check("t2_swap_one_cycle", 256'(bus.swap_pulse), 256'd0);

    // Test 3: writes and a second commit during PEND are ignored
    do_commit();
    check("t3_wr_ready", 256'(bus.wr_ready), 256'd0);
    bus.wr_valid = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h7FFF; bus.commit = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.commit = 1'b0;
    bus.phase_strobe = 1'b1;
    tick();
    bus.phase_strobe = 1'b0;
    wait_swap("t3_swap");
    repeat (4) tick();

    // Test 4: cke_div=0, swap slot forces one low cycle, deferred cke follows
    bus.cke_div = 8'd0;
    repeat (8) tick();
    check("t4_cke_cont", 256'(bus.cke), 256'd1);
    wr(5, 16'h1234);
    do_commit();
    bus.phase_strobe = 1'b1;
    tick();
    bus.phase_strobe = 1'b0;
    check("t4_cke_a0", 256'(bus.cke), 256'd1);
    tick();
    check("t4_cke_swap", 256'(bus.cke), 256'd0);
    tick();
    check("t4_cke_after", 256'(bus.cke), 256'd1);
    check("t4_swap", 256'(bus.swap_pulse), 256'd1);
    tick();
    check("t4_cke_cont2", 256'(bus.cke), 256'd1);

    // Test 5: TAP_LEN=12 instance, out-of-range write and error clearing
    b12.wr_valid = 1'b1; b12.wr_addr = 4'd11; b12.wr_data = 16'h0ABC;
    tick();
    b12.wr_addr = 4'd13; b12.wr_data = 16'h5555;
    tick();
    b12.wr_valid = 1'b0;
    check("t5_err_set", 256'(b12.addr_err), 256'd1);
    b12.commit = 1'b1;
    tick();
    b12.commit = 1'b0;
    for (int k = 0; k < 10 && b12.swap_pulse !== 1'b1; k++) tick();
    exp12 = '0;
    exp12[11*16 +: 16] = 16'h0ABC;
    check("t5_swap", 256'(b12.swap_pulse), 256'd1);
    check("t5_tap", 256'(b12.tap), 256'(exp12));
    b12.err_clr = 1'b1;
    tick();
    check("t5_err_clr", 256'(b12.addr_err), 256'd0);
    b12.wr_valid = 1'b1; b12.wr_addr = 4'd13;
    tick();
    b12.wr_valid = 1'b0;
    check("t5_set_wins", 256'(b12.addr_err), 256'd1);
    tick();
    b12.err_clr = 1'b0;
    check("t5_err_clr2", 256'(b12.addr_err), 256'd0);

    // Test 6: run=0 commit swaps without a strobe; reset mid-PEND drops the commit
    bus.run = 1'b0;
    wr(0, 16'h8001);
    do_commit();
    wait_swap("t6_swap_run0");
    bus.run = 1'b1;
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
    check("t6_busy_pend", 256'(bus.busy), 256'd1);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) shm[i] = '0;
    check("t6_rst_busy", 256'(bus.busy), 256'd0);
    check("t6_rst_tap", bus.tap, 256'd0);
    check("t6_rst_swap", 256'(bus.swap_pulse), 256'd0);
    check("t6_rst_wr_ready", 256'(bus.wr_ready), 256'd1);
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    bus.run = 1'b0;
    do_commit();
    wait_swap("t6_swap_zero_shadow");
    check("t6_cke_idle", 256'(bus.cke), 256'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
